// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer for a multi-cycle req/ack instruction memory.
// Optional watchdog is enabled with `define FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PCF,
    input  logic [31:0] PCNextF,
    input  logic        PCSrcE,
    input  logic        StallIn,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] InstrF,
    output logic        StallF,
    output logic        FlushD,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] held;
    logic        acked;
    logic        avail;
    logic        timeout;
    logic        unused_cfg;

    assign unused_cfg = ^RESET_PC;

    assign acked  = (state == WAIT) && mem_ack;
    assign avail  = acked || (state == HOLD);
    assign InstrF = acked ? mem_rdata :
                    (state == HOLD) ? held : NOP_INSTR;
    assign StallF = !(PCSrcE || (avail && !StallIn));
    assign FlushD = PCSrcE || (!avail && !StallIn);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CW-1:0] cnt;
    logic          err_q;
    logic          waiting;
    logic          bump;

    assign waiting   = (state == WAIT) || (state == DROP);
    // A redirect out of WAIT starts a fresh DROP window, so it never counts.
    assign bump      = waiting && !mem_ack
                       && !((state == WAIT) && PCSrcE);
    assign timeout   = bump && (cnt == CW'(TIMEOUT - 1));
    assign fetch_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (timeout) begin
            cnt   <= '0;
            err_q <= 1'b1;
        end else if (bump) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`else
    logic unused_to;

    assign unused_to = ^32'(TIMEOUT);
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            held     <= NOP_INSTR;
        end else if (timeout) begin
            state   <= IDLE;
            mem_req <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state    <= WAIT;
                    mem_req  <= 1'b1;
                    mem_addr <= PCF;
                end
                WAIT: begin
                    if (PCSrcE && !mem_ack) begin
                        state <= DROP;
                    end else if (mem_ack && (PCSrcE || !StallIn)) begin
                        mem_addr <= PCNextF;
                    end else if (mem_ack) begin
                        held    <= mem_rdata;
                        state   <= HOLD;
                        mem_req <= 1'b0;
                    end
                end
                HOLD: begin
                    if (PCSrcE || !StallIn) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= PCNextF;
                    end
                end
                DROP: begin
                    // pcreg loads PCNextF on a redirect, otherwise PCF is the target.
                    if (mem_ack) begin
                        state    <= WAIT;
                        mem_addr <= PCSrcE ? PCNextF : PCF;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed plan steps plus randomized traffic
// checked against a request/hold bookkeeping model.
module tb_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TO  = 4;
`ifdef FETCH_TIMEOUT_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PCF, PCNextF, mem_addr, mem_rdata, InstrF;
    logic        PCSrcE, StallIn, mem_req, mem_ack;
    logic        StallF, FlushD, fetch_err;

    always #5 clk = ~clk;

    fetch_ctrl #(
        .RESET_PC (32'h0),
        .NOP_INSTR(NOP),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PCF      (PCF),
        .PCNextF  (PCNextF),
        .PCSrcE   (PCSrcE),
        .StallIn  (StallIn),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .InstrF   (InstrF),
        .StallF   (StallF),
        .FlushD   (FlushD),
        .fetch_err(fetch_err)
    );

    int total = 0;
    int bad   = 0;

    // model: first cycle after reset, request in flight, its response
    // already doomed, instruction parked for if_id
    bit          idle, outst, stale, hv, err;
    logic [31:0] held, addr, pc;
    int          cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        PCSrcE  = 1'b0;
        StallIn = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle  = 1'b1;
        outst = 1'b0;
        stale = 1'b0;
        hv    = 1'b0;
        err   = 1'b0;
        held  = NOP;
        addr  = 32'h0;
        cnt   = 0;
        pc    = 32'h0;
        chk1("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk1("rst_err", fetch_err, 1'b0);
    endtask

    task automatic step(input logic src, input logic stl, input logic ack,
                        input logic [31:0] tgt, input logic [31:0] rd);
        logic [31:0] exp_i, pc_old, nxt;
        logic        fresh, av, esf, efd;
        pc_old    = pc;
        nxt       = src ? tgt : pc + 32'd4;
        PCSrcE    = src;
        StallIn   = stl;
        mem_ack   = ack;
        mem_rdata = rd;
        PCF       = pc;
        PCNextF   = nxt;
        #1;
        fresh = outst && !stale && ack;
        av    = fresh || hv;
        exp_i = fresh ? rd : (hv ? held : NOP);
        esf   = !(src || (av && !stl));
        efd   = src || (!av && !stl);
        chk1("req", mem_req, outst);
        chk("addr", mem_addr, addr);
        chk("instr", InstrF, exp_i);
        chk1("stallf", StallF, esf);
        chk1("flushd", FlushD, efd);
        chk1("err", fetch_err, err);
        @(posedge clk);
        if (!esf) pc = nxt;
        if (idle) begin
            idle  = 1'b0;
            outst = 1'b1;
            stale = 1'b0;
            addr  = pc_old;
            cnt   = 0;
        end else if (outst) begin
            if (ack) begin
                if (stale) addr = src ? nxt : pc_old;
                else if (src || !stl) addr = nxt;
                else begin
                    outst = 1'b0;
                    hv    = 1'b1;
                    held  = rd;
                end
                stale = 1'b0;
                cnt   = 0;
            end else if (src && !stale) begin
                stale = 1'b1;
                cnt   = 0;
            end else begin
                cnt++;
                if (TEN && cnt == TO) begin
                    err   = 1'b1;
                    outst = 1'b0;
                    stale = 1'b0;
                    idle  = 1'b1;
                    cnt   = 0;
                end
            end
        end else if (hv && (src || !stl)) begin
            hv    = 1'b0;
            outst = 1'b1;
            addr  = nxt;
        end
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        PCF       = '0;
        PCNextF   = '0;
        mem_rdata = '0;
        do_reset();
        chk("rst_instr", InstrF, NOP);

        // sequential stream with 1-cycle ack
        step(0, 0, 0, 0, $urandom);
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", mem_addr, 32'(4 * i));
            step(0, 0, 1, 0, $urandom);
        end

        // 3-cycle ack at 0x10
        do_reset();
        pc = 32'h10;
        step(0, 0, 0, 0, $urandom);
        step(0, 0, 0, 0, $urandom);
        step(0, 0, 0, 0, $urandom);
        chk("lat_addr", mem_addr, 32'h10);
        step(0, 0, 1, 0, $urandom);

        // ack under stall parks in HOLD
        step(0, 1, 1, 0, 32'h0050_0093);
        chk("hold_instr", InstrF, 32'h0050_0093);
        step(0, 1, 0, 0, $urandom);
        step(0, 0, 0, 0, $urandom);

        // redirect mid-fetch at 0x20
        do_reset();
        pc = 32'h20;
        step(0, 0, 0, 0, $urandom);
        step(0, 0, 0, 0, $urandom);
        step(1, 0, 0, 32'h40, $urandom);
        step(0, 0, 0, 0, $urandom);
        step(0, 0, 1, 0, 32'hDEAD_BEEF);
        chk("drop_addr", mem_addr, 32'h40);

        // redirect coincident with ack
        step(1, 0, 1, 32'h80, $urandom);
        chk("coin_addr", mem_addr, 32'h80);
        chk1("coin_req", mem_req, 1'b1);
        step(0, 0, 1, 0, $urandom);

        // reset with a request outstanding
        step(0, 0, 0, 0, $urandom);
        do_reset();

`ifdef FETCH_TIMEOUT_EN
        step(0, 0, 0, 0, $urandom);
        for (int i = 0; i < TO; i++) step(0, 0, 0, 0, $urandom);
        chk1("to_err", fetch_err, 1'b1);
        chk1("to_req", mem_req, 1'b0);
        step(0, 0, 0, 0, $urandom);
        step(0, 0, 1, 0, $urandom);
        chk1("to_sticky", fetch_err, 1'b1);
        do_reset();
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic s, t, a;
            s = ($urandom_range(0, 5) == 0);
            t = ($urandom_range(0, 2) == 0);
            a = outst && ($urandom_range(0, 2) != 0);
            step(s, t, a, $urandom & 32'hFFFF_FFFC, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
